// File: rtl/tetris_pkg.sv
// Shared move-command encoding, sequencer state type and gravity period helper.
package tetris_pkg;

    typedef enum logic [2:0] {
        OP_NONE    = 3'd0,
        OP_ROTATE  = 3'd1,
        OP_LEFT    = 3'd2,
        OP_RIGHT   = 3'd3,
        OP_DOWN    = 3'd4,
        OP_GRAVITY = 3'd5
    } move_op_t;

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_ISSUE = 1'b1
    } seq_state_t;

    // Period halves per level, floored at min_p.
    function automatic int unsigned gravity_period(
        input int unsigned base,
        input int unsigned min_p,
        input int unsigned level
    );
        int unsigned p;
        p = base >> level;
        return (p < min_p) ? min_p : p;
    endfunction

endpackage

// File: rtl/move_fifo.sv
// Synchronous FIFO of move ops; a push into a full queue is accepted when a pop happens on the same cycle.
module move_fifo
    import tetris_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     flush,
    input  logic                     push,
    input  logic                     pop,
    input  logic [2:0]               din,
    output logic [2:0]               dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [2:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_q, wr_d;
    logic [AW-1:0] rd_q, rd_d;
    logic [CW-1:0] count_q, count_d;
    logic          push_ok, pop_ok;

    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);
    assign count = count_q;
    assign dout  = mem_q[rd_q];

    assign pop_ok  = pop && !empty;
    assign push_ok = push && (!full || pop_ok);

    always_comb begin
        wr_d    = wr_q;
        rd_d    = rd_q;
        count_d = count_q;
        if (push_ok) wr_d = wr_q + AW'(1);
        if (pop_ok)  rd_d = rd_q + AW'(1);
        if (push_ok && !pop_ok)      count_d = count_q + CW'(1);
        else if (pop_ok && !push_ok) count_d = count_q - CW'(1);
    end

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
        end else begin
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_q] <= din;
    end

endmodule

// File: rtl/move_sequencer.sv
// Gravity tick generator, user-move priority encoder and single-command valid/ready issuer.
module move_sequencer
    import tetris_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH  = 4,
    parameter int unsigned BASE_PERIOD = 50_000_000,
    parameter int unsigned MIN_PERIOD  = 2_500_000,
    parameter int unsigned LVL_W       = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          enable,
    input  logic                          rotate,
    input  logic                          down,
    input  logic                          left,
    input  logic                          right,
    input  logic [LVL_W-1:0]              speed_level,
    input  logic                          cmd_ready,
    output logic                          cmd_valid,
    output logic [2:0]                    cmd_op,
    output logic [$clog2(FIFO_DEPTH):0]   queue_count,
    output logic                          dropped
);

    localparam int unsigned GC_W = $clog2(BASE_PERIOD) + 1;

    logic [GC_W-1:0] gc_q, gc_d;
    logic [GC_W-1:0] period_m1;
    logic            pending_q, pending_d;
    logic            dropped_q, dropped_d;
    logic            tick, consume;
    seq_state_t      state_q, state_d;
    move_op_t        op_q, op_d;
    move_op_t        push_op;
    logic            push_req, multi;
    logic            fifo_pop, fifo_full, fifo_empty;
    logic [2:0]      fifo_dout;
    logic            src_grav, src_user, load;

    assign period_m1 = GC_W'(gravity_period(BASE_PERIOD, MIN_PERIOD, 32'(speed_level)) - 1);

    // Down resets the drop timer; a period shrunk below gc wraps without a tick.
    always_comb begin
        gc_d = gc_q;
        tick = 1'b0;
        if (!enable)                 gc_d = '0;
        else if (down)               gc_d = '0;
        else if (gc_q == period_m1) begin
            gc_d = '0;
            tick = 1'b1;
        end
        else if (gc_q > period_m1)   gc_d = '0;
        else                         gc_d = gc_q + GC_W'(1);
        pending_d = enable && ((pending_q && !consume) || tick);
    end

    always_comb begin
        push_op = OP_NONE;
        if (rotate)     push_op = OP_ROTATE;
        else if (left)  push_op = OP_LEFT;
        else if (right) push_op = OP_RIGHT;
        else if (down)  push_op = OP_DOWN;
        push_req  = enable && (rotate || left || right || down);
        multi     = (rotate && (left || right || down)) || (left && (right || down)) || (right && down);
        dropped_d = dropped_q || (enable && (multi || (push_req && fifo_full && !fifo_pop)));
    end

    move_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .flush (!enable),
        .push  (push_req),
        .pop   (fifo_pop),
        .din   (push_op),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (queue_count)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            op_q      <= OP_NONE;
            gc_q      <= '0;
            pending_q <= 1'b0;
            dropped_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            gc_q      <= gc_d;
            pending_q <= pending_d;
            dropped_q <= dropped_d;
        end
    end

    // A handshake and the next load share one edge so commands can issue back-to-back.
    always_comb begin
        src_grav = enable && pending_q;
        src_user = enable && !fifo_empty;
        load     = ((state_q == S_IDLE) || cmd_ready) && (src_grav || src_user);
        consume  = load && src_grav;
        fifo_pop = load && !src_grav;
        state_d  = state_q;
        op_d     = op_q;
        if (load) begin
            state_d = S_ISSUE;
            op_d    = src_grav ? OP_GRAVITY : move_op_t'(fifo_dout);
        end else if ((state_q == S_ISSUE) && cmd_ready) begin
            state_d = S_IDLE;
            op_d    = OP_NONE;
        end
    end

    always_comb begin
        cmd_valid = (state_q == S_ISSUE);
        cmd_op    = op_q;
        dropped   = dropped_q;
    end

endmodule

// File: tb/tb_move_sequencer.sv
// Directed bench for move_sequencer with a scoreboard of expected issued commands.
module tb_move_sequencer;
    import tetris_pkg::*;

    logic       clk = 1'b0;
    logic       reset, enable, rotate, down, left, right, cmd_ready;
    logic [3:0] speed_level;
    logic       cmd_valid, dropped;
    logic [2:0] cmd_op;
    logic [2:0] queue_count;

    int         checks   = 0;
    int         failures = 0;
    logic [2:0] exp_q [$];
    int         n;

    always #5 clk = ~clk;

    move_sequencer #(
        .FIFO_DEPTH  (4),
        .BASE_PERIOD (16),
        .MIN_PERIOD  (4),
        .LVL_W       (4)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .enable      (enable),
        .rotate      (rotate),
        .down        (down),
        .left        (left),
        .right       (right),
        .speed_level (speed_level),
        .cmd_ready   (cmd_ready),
        .cmd_valid   (cmd_valid),
        .cmd_op      (cmd_op),
        .queue_count (queue_count),
        .dropped     (dropped)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic wait_valid(input int limit, output int cnt);
        cnt = 0;
        do begin
            tick();
            cnt++;
        end while (!cmd_valid && cnt < limit);
    endtask

    // Every accepted command must match the head of the expected-command queue.
    always @(negedge clk) begin
        if (!reset && cmd_valid && cmd_ready) begin
            if (exp_q.size() == 0) begin
                check("sb_extra_cmd", 32'(exp_q.size()), 1);
            end else begin
                logic [2:0] e;
                e = exp_q.pop_front();
                check("sb_op", 32'(cmd_op), 32'(e));
            end
        end
    end

    initial begin
        reset = 1'b1; enable = 1'b1; cmd_ready = 1'b1; speed_level = 4'd0;
        rotate = 1'b0; down = 1'b0; left = 1'b0; right = 1'b0;
        tick();
        tick();
        check("rst_valid", cmd_valid, 0);
        check("rst_op", cmd_op, OP_NONE);
        check("rst_count", queue_count, 0);
        check("rst_dropped", dropped, 0);

        // Gravity at level 0: first command 17 cycles after reset, then every 16.
        exp_q.push_back(OP_GRAVITY);
        exp_q.push_back(OP_GRAVITY);
        reset = 1'b0;
        wait_valid(40, n);
        check("grav_first_latency", n, 17);
        check("grav_first_op", cmd_op, OP_GRAVITY);
        wait_valid(40, n);
        check("grav_period", n, 16);
        tick();
        check("grav_one_cycle", cmd_valid, 0);
        enable = 1'b0;
        tick();
        tick();

        // Single left pulse.
        enable = 1'b1;
        left = 1'b1;
        exp_q.push_back(OP_LEFT);
        tick();
        left = 1'b0;
        check("left_not_yet_valid", cmd_valid, 0);
        check("left_queued", queue_count, 1);
        tick();
        check("left_valid", cmd_valid, 1);
        check("left_op", cmd_op, OP_LEFT);
        check("left_dequeued", queue_count, 0);
        tick();
        check("left_one_cycle", cmd_valid, 0);
        enable = 1'b0;
        tick();

        // Six right pulses with the engine stalled: one held, four queued, one dropped.
        enable = 1'b1;
        cmd_ready = 1'b0;
        right = 1'b1;
        repeat (5) exp_q.push_back(OP_RIGHT);
        repeat (6) tick();
        right = 1'b0;
        check("full_count", queue_count, 4);
        check("full_dropped", dropped, 1);
        check("full_valid", cmd_valid, 1);
        check("full_op", cmd_op, OP_RIGHT);
        cmd_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("burst_valid", cmd_valid, 1);
        end
        tick();
        check("burst_end", cmd_valid, 0);
        check("burst_count", queue_count, 0);
        enable = 1'b0;
        tick();

        // Reset clears dropped; pulses while disabled are ignored silently.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("rst2_dropped", dropped, 0);
        rotate = 1'b1; left = 1'b1;
        tick();
        rotate = 1'b0; left = 1'b0;
        check("dis_count", queue_count, 0);
        check("dis_dropped", dropped, 0);

        // Rotate beats left in the same cycle.
        enable = 1'b1;
        rotate = 1'b1; left = 1'b1;
        exp_q.push_back(OP_ROTATE);
        tick();
        rotate = 1'b0; left = 1'b0;
        check("prio_dropped", dropped, 1);
        check("prio_count", queue_count, 1);
        tick();
        check("prio_valid", cmd_valid, 1);
        check("prio_op", cmd_op, OP_ROTATE);
        tick();
        check("prio_end", cmd_valid, 0);
        enable = 1'b0;
        tick();

        // Level 3: period floored to 4; down pulse restarts the timer.
        speed_level = 4'd3;
        enable = 1'b1;
        exp_q.push_back(OP_GRAVITY);
        exp_q.push_back(OP_GRAVITY);
        wait_valid(20, n);
        check("lvl3_first", n, 5);
        wait_valid(20, n);
        check("lvl3_period", n, 4);
        tick();
        check("lvl3_gap", cmd_valid, 0);
        down = 1'b1;
        exp_q.push_back(OP_DOWN);
        exp_q.push_back(OP_GRAVITY);
        tick();
        down = 1'b0;
        check("down_queued_valid", cmd_valid, 0);
        tick();
        check("down_valid", cmd_valid, 1);
        check("down_op", cmd_op, OP_DOWN);
        wait_valid(20, n);
        check("down_restart", n, 4);
        check("down_grav_op", cmd_op, OP_GRAVITY);
        enable = 1'b0;
        tick();
        tick();

        // Shrinking the period below the counter wraps it with no tick.
        speed_level = 4'd0;
        enable = 1'b1;
        repeat (10) tick();
        speed_level = 4'd3;
        exp_q.push_back(OP_GRAVITY);
        wait_valid(20, n);
        check("shrink_wrap", n, 6);
        enable = 1'b0;
        tick();
        tick();
        speed_level = 4'd0;

        // Disable with a command in flight and two queued.
        enable = 1'b1;
        cmd_ready = 1'b0;
        exp_q.push_back(OP_LEFT);
        left = 1'b1;
        tick();
        left = 1'b0;
        right = 1'b1;
        tick();
        right = 1'b0;
        down = 1'b1;
        tick();
        down = 1'b0;
        check("inflight_valid", cmd_valid, 1);
        check("inflight_op", cmd_op, OP_LEFT);
        check("inflight_count", queue_count, 2);
        enable = 1'b0;
        tick();
        check("flush_count", queue_count, 0);
        check("flush_held_valid", cmd_valid, 1);
        check("flush_held_op", cmd_op, OP_LEFT);
        repeat (20) tick();
        check("hold_valid", cmd_valid, 1);
        check("hold_op", cmd_op, OP_LEFT);
        cmd_ready = 1'b1;
        tick();
        check("disabled_idle", cmd_valid, 0);
        repeat (20) tick();
        check("no_grav_disabled", cmd_valid, 0);

        check("sb_drained", 32'(exp_q.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
